// File: rtl/tube_scan_capture.sv
// Tube bus readback: debounces each multiplexed digit, decodes 7-segment patterns, publishes full frames.
// Optional capture error counter (err_cnt) enabled by defining TUBE_CAP_ERRCNT_EN.

module tube_cap_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [3:0] code,
  output logic [3:0] shadow,
  output logic       seen
);
  // Write beats clear so a capture landing on the publish edge opens the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= 4'hF;
      seen   <= 1'b0;
    end else begin
      if (clr) seen <= 1'b0;
      if (wr) begin
        shadow <= code;
        seen   <= 1'b1;
      end
    end
  end
endmodule

module tube_scan_capture #(
  parameter int NDIG   = 4,
  parameter int SETTLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] digits_out,
  output logic              frame_valid,
  output logic              pat_err,
`ifdef TUBE_CAP_ERRCNT_EN
  output logic              sel_err,
  output logic [7:0]        err_cnt
`else
  output logic              sel_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

  function automatic logic [3:0] seg_decode(input logic [7:0] s);
    logic [3:0] d;
    d = 4'hE;
    if (s[7]) begin
      case (s[6:0])
        7'h3F: d = 4'd0;
        7'h06: d = 4'd1;
        7'h5B: d = 4'd2;
        7'h4F: d = 4'd3;
        7'h66: d = 4'd4;
        7'h6D: d = 4'd5;
        7'h7D: d = 4'd6;
        7'h07: d = 4'd7;
        7'h7F: d = 4'd8;
        7'h6F: d = 4'd9;
        7'h00: d = 4'hF;
        default: d = 4'hE;
      endcase
    end
    return d;
  endfunction

  state_t                  state;
  logic [7:0]              snap_seg;
  logic [NDIG-1:0]         snap_sel;
  logic [3:0]              cnt;
  logic                    sel_ok, same_in, sel_chg, load, cap, settle_done, frame_go;
  logic [3:0]              cap_code;
  logic [NDIG-1:0]         wr_vec, seen;
  logic [NDIG-1:0][3:0]    shadow;

  assign sel_ok      = $onehot(dig_sel);
  assign sel_chg     = (dig_sel != snap_sel);
  assign same_in     = (seg_in == snap_seg) && !sel_chg;
  assign settle_done = ({1'b0, cnt} + 5'd1) >= 5'(SETTLE);
  assign cap         = (state == S_CAPTURE) && sel_ok;
  assign cap_code    = seg_decode(snap_seg);
  assign wr_vec      = cap ? snap_sel : '0;
  assign frame_go    = &seen;

  // A select change while capturing or holding starts the next digit on the same edge,
  // so a scan dwelling exactly SETTLE cycles per digit is still followed.
  always_comb begin
    load = 1'b0;
    if (sel_ok) begin
      case (state)
        S_IDLE:    load = 1'b1;
        S_SETTLE:  load = !same_in;
        S_CAPTURE: load = sel_chg;
        S_HOLD:    load = sel_chg;
        default:   load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      snap_seg <= '0;
      snap_sel <= '0;
      cnt      <= '0;
      sel_err  <= 1'b0;
      pat_err  <= 1'b0;
    end else begin
      sel_err <= !sel_ok;
      if (cap && cap_code == 4'hE) pat_err <= 1'b1;
      if (!sel_ok) begin
        state <= S_IDLE;
      end else if (load) begin
        snap_seg <= seg_in;
        snap_sel <= dig_sel;
        cnt      <= 4'd1;
        state    <= (SETTLE == 1) ? S_CAPTURE : S_SETTLE;
      end else begin
        case (state)
          S_SETTLE: begin
            cnt <= cnt + 4'd1;
            if (settle_done) state <= S_CAPTURE;
          end
          S_CAPTURE: state <= S_HOLD;
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
      tube_cap_digit u_dig (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wr_vec[i]),
        .clr    (frame_go),
        .code   (cap_code),
        .shadow (shadow[i]),
        .seen   (seen[i])
      );
    end
  endgenerate

  // Publish one edge after the last digit lands; shadow already holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '1;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_go;
      if (frame_go) digits_out <= shadow;
    end
  end

`ifdef TUBE_CAP_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= 8'h00;
    else if (cap && cap_code == 4'hE && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
